shift_sequencer: RTL and testbench

Multi-cycle controller that drives the operand-2 barrel-shift path of the ARM datapath. It accepts one decoded shift request and resolves the effective shift count and ARM special cases (#0 encodings, RRX, register amounts ≥32). It then steps the operand one bit per cycle and returns the 32-bit result with the shifter carry-out. It sits between the decode stage and the ALU B-input and stalls decode through a valid/ready handshake.

---
 rtl/arm_shift_pkg.sv | 42 ++++
 rtl/shift_step.sv | 47 ++++
 rtl/shift_sequencer.sv | 153 +++++++++++++++
 tb/tb_shift_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arm_shift_pkg.sv
// Shared types and constants for the ARM operand-2 shift sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package arm_shift_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // Architectural shift-type field encodings (instruction bits [6:5]).
  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // Internal step operation; RRX has no architectural code of its own.
  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b011,
    OP_RRX = 3'b100
  } step_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Map an architectural shift type onto the matching step operation.
  function automatic step_op_t to_step_op(input logic [1:0] t);
    step_op_t r;
    case (t)
      LSL:     r = OP_LSL;
      LSR:     r = OP_LSR;
      ASR:     r = OP_ASR;
      default: r = OP_ROR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift step: applies one LSL/LSR/ASR/ROR/RRX position to operand and carry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning sequencer decides when a step is committed.
module shift_step
  import arm_shift_pkg::*;
(
  input  logic [WIDTH-1:0] i_op,
  input  logic             i_c,
  input  step_op_t         i_type,
  output logic [WIDTH-1:0] o_op,
  output logic             o_c
);

  // One-position shift; carry takes the bit that falls off the end.
  always_comb begin
    o_op = i_op;
    o_c  = i_c;
    case (i_type)
      OP_LSL: begin
        o_c  = i_op[WIDTH-1];
        o_op = {i_op[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        o_c  = i_op[0];
        o_op = {1'b0, i_op[WIDTH-1:1]};
      end
      OP_ASR: begin
        o_c  = i_op[0];
        o_op = {i_op[WIDTH-1], i_op[WIDTH-1:1]};
      end
      OP_ROR: begin
        o_c  = i_op[0];
        o_op = {i_op[0], i_op[WIDTH-1:1]};
      end
      OP_RRX: begin
        // RRX runs exactly one step, so i_c is still the latched CPSR C here.
        o_c  = i_op[0];
        o_op = {i_c, i_op[WIDTH-1:1]};
      end
      default: begin
        o_op = i_op;
        o_c  = i_c;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Operand-2 barrel-shift sequencer: decodes the ARM shift count, then steps one bit per cycle.
// Latency: n+1 cycles from accept edge to o_out_valid (n = effective count, 0..33).
// Backpressure: o_in_ready only in IDLE; result/carry held in DONE until i_out_ready.
module shift_sequencer
  import arm_shift_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_rm,
  input  logic [7:0]       i_rs_low,
  input  logic [11:0]      i_imm12,
  input  logic             i_is_imm,
  input  logic             i_carry_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op;
  logic             r_c;
  step_op_t         r_type;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_op_ld;
  step_op_t         w_type_ld;
  logic [CNT_W-1:0] w_n;
  logic [WIDTH-1:0] w_step_op;
  logic             w_step_c;

  logic [4:0]       w_shamt;
  logic [1:0]       w_sty;
  logic             w_regflag;
  logic [3:0]       w_rot4;
  logic [7:0]       w_imm8;

  assign w_rot4    = i_imm12[11:8];
  assign w_imm8    = i_imm12[7:0];
  assign w_shamt   = i_imm12[11:7];
  assign w_sty     = i_imm12[6:5];
  assign w_regflag = i_imm12[4];

  // Resolve operand, step type and effective count, folding in the ARM special encodings.
  always_comb begin
    w_op_ld   = i_rm;
    w_type_ld = to_step_op(w_sty);
    w_n       = '0;
    if (i_is_imm) begin
      // Rotated immediate: ROR of the zero-extended byte by twice rot4.
      w_op_ld   = {{(WIDTH-8){1'b0}}, w_imm8};
      w_type_ld = OP_ROR;
      w_n       = {1'b0, w_rot4, 1'b0};
    end else if (!w_regflag) begin
      case (w_sty)
        LSL: w_n = {1'b0, w_shamt};
        LSR, ASR: w_n = (w_shamt == 5'd0) ? CNT_W'(32) : {1'b0, w_shamt};
        default: begin
          if (w_shamt == 5'd0) begin
            // ROR #0 encodes RRX: a single step through the carry.
            w_type_ld = OP_RRX;
            w_n       = CNT_W'(1);
          end else begin
            w_n = {1'b0, w_shamt};
          end
        end
      endcase
    end else if (i_rs_low != 8'd0) begin
      case (w_sty)
        // Counts past 32 saturate at 33, which shifts every bit out including the carry.
        LSL, LSR: w_n = (i_rs_low >= 8'd33) ? CNT_W'(33) : i_rs_low[CNT_W-1:0];
        // ASR saturates at 32: result is all sign bits and carry is the sign.
        ASR: w_n = (i_rs_low >= 8'd32) ? CNT_W'(32) : i_rs_low[CNT_W-1:0];
        // Register ROR works modulo 32, with a multiple of 32 stepping a full turn.
        default: w_n = (i_rs_low[4:0] == 5'd0) ? CNT_W'(32) : {1'b0, i_rs_low[4:0]};
      endcase
    end
  end

  shift_step u_step (
    .i_op   (r_op),
    .i_c    (r_c),
    .i_type (r_type),
    .o_op   (w_step_op),
    .o_c    (w_step_c)
  );

  // State register; reset wins over any in-flight request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes; handshake inputs only steer the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = (w_n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand, carry, step type and remaining count: load on accept, update per step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op   <= '0;
      r_c    <= 1'b0;
      r_type <= OP_LSL;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_op   <= w_op_ld;
      r_c    <= i_carry_in;
      r_type <= w_type_ld;
      r_cnt  <= w_n;
    end else if (w_step) begin
      r_op   <= w_step_op;
      r_c    <= w_step_c;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_result    = r_op;
  assign o_carry_out = r_c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed results, carries and latencies.
// Latency: measured in rising edges from the accept edge (inclusive) to o_out_valid.
// Backpressure: exercises a held DONE with a competing request, and a mid-SHIFT reset.
module tb_shift_sequencer;

  logic        clk;
  logic        i_reset;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_rm;
  logic [7:0]  i_rs_low;
  logic [11:0] i_imm12;
  logic        i_is_imm;
  logic        i_carry_in;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_result;
  logic        o_carry_out;

  int n_total = 0;
  int n_bad   = 0;

  shift_sequencer dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_rm        (i_rm),
    .i_rs_low    (i_rs_low),
    .i_imm12     (i_imm12),
    .i_is_imm    (i_is_imm),
    .i_carry_in  (i_carry_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_carry_out (o_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute backstop so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic imm, input logic [31:0] rm, input logic [7:0] rs,
                           input logic [11:0] f, input logic cin);
    i_is_imm   = imm;
    i_rm       = rm;
    i_rs_low   = rs;
    i_imm12    = f;
    i_carry_in = cin;
    i_in_valid = 1'b1;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_out_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, {31'd0, o_out_valid}, 32'd0);
    chk({tag, "_irdy_back"}, {31'd0, o_in_ready}, 32'd1);
  endtask

  task automatic run_case(input string tag, input logic imm, input logic [31:0] rm,
                          input logic [7:0] rs, input logic [11:0] f, input logic cin,
                          input logic [31:0] exp_res, input logic exp_c, input int exp_lat);
    int lat;
    @(negedge clk);
    drive_req(imm, rm, rs, f, cin);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, o_result, exp_res);
    chk({tag, "_c"}, {31'd0, o_carry_out}, {31'd0, exp_c});
    handshake(tag);
  endtask

  initial begin
    int lat;
    i_reset     = 1'b1;
    i_in_valid  = 1'b0;
    i_rm        = '0;
    i_rs_low    = '0;
    i_imm12     = '0;
    i_is_imm    = 1'b0;
    i_carry_in  = 1'b0;
    i_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irdy", {31'd0, o_in_ready}, 32'd1);
    chk("rst_ovld", {31'd0, o_out_valid}, 32'd0);
    chk("rst_res", o_result, 32'd0);
    chk("rst_c", {31'd0, o_carry_out}, 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    //        tag          imm   rm            rs      imm12    cin   result        C     lat
    run_case("imm_rot4",   1'b1, 32'h0,        8'd0,   12'h4FF, 1'b0, 32'hFF000000, 1'b1, 9);
    run_case("imm_rot0",   1'b1, 32'h0,        8'd0,   12'h0AB, 1'b1, 32'h000000AB, 1'b1, 1);
    run_case("lsr_0",      1'b0, 32'h80000001, 8'd0,   12'h020, 1'b0, 32'h00000000, 1'b1, 33);
    run_case("rrx",        1'b0, 32'h00000003, 8'd0,   12'h060, 1'b1, 32'h80000001, 1'b1, 2);
    run_case("lsl_imm4",   1'b0, 32'h0000000F, 8'd0,   12'h200, 1'b1, 32'h000000F0, 1'b0, 5);
    run_case("asr_0",      1'b0, 32'h7FFFFFFF, 8'd0,   12'h040, 1'b1, 32'h00000000, 1'b0, 33);
    run_case("lsl_r0",     1'b0, 32'h0000000F, 8'd0,   12'h010, 1'b1, 32'h0000000F, 1'b1, 1);
    run_case("lsl_r40",    1'b0, 32'h0000000F, 8'd40,  12'h010, 1'b1, 32'h00000000, 1'b0, 34);
    run_case("asr_r200",   1'b0, 32'h80000000, 8'd200, 12'h050, 1'b0, 32'hFFFFFFFF, 1'b1, 33);
    run_case("lsr_r32",    1'b0, 32'h8000000F, 8'd32,  12'h030, 1'b0, 32'h00000000, 1'b1, 33);
    run_case("ror_r32",    1'b0, 32'h8000000F, 8'd32,  12'h070, 1'b0, 32'h8000000F, 1'b1, 33);
    run_case("ror_r4",     1'b0, 32'h0000000F, 8'd4,   12'h070, 1'b0, 32'hF0000000, 1'b1, 5);

    // Backpressure: result held in DONE, competing request ignored until handshake.
    @(negedge clk);
    drive_req(1'b0, 32'h0000000F, 8'd0, 12'h200, 1'b0);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive_req(1'b1, 32'h0, 8'd0, 12'h0FF, 1'b1);
      @(posedge clk);
      #1;
      chk("bp_hold_res", o_result, 32'h000000F0);
      chk("bp_hold_ovld", {31'd0, o_out_valid}, 32'd1);
      chk("bp_hold_irdy", {31'd0, o_in_ready}, 32'd0);
    end
    handshake("bp");
    // The held request is taken on the very next edge; n=0 so DONE follows immediately.
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    chk("bp_next_irdy", {31'd0, o_in_ready}, 32'd0);
    chk("bp_next_ovld", {31'd0, o_out_valid}, 32'd1);
    chk("bp_next_res", o_result, 32'h000000FF);
    chk("bp_next_c", {31'd0, o_carry_out}, 32'd1);
    handshake("bp_next");

    // Reset in the middle of an LSL #20 aborts it with no output.
    @(negedge clk);
    drive_req(1'b0, 32'h0000000F, 8'd0, 12'hA00, 1'b1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_ovld", {31'd0, o_out_valid}, 32'd0);
    chk("mid_irdy", {31'd0, o_in_ready}, 32'd0);
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_irdy", {31'd0, o_in_ready}, 32'd1);
    chk("abort_ovld", {31'd0, o_out_valid}, 32'd0);
    chk("abort_res", o_result, 32'd0);
    chk("abort_c", {31'd0, o_carry_out}, 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    run_case("post_rst",   1'b0, 32'h0000000F, 8'd0,   12'hA00, 1'b1, 32'h00F00000, 1'b0, 21);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
